// File: rtl/pulse_timing_generator_if.sv
// Configuration and status bundle for pulse_timing_generator.
//   master : register bank side (drives enable and timing config, reads status)
//   slave  : the timing generator itself
// Signals:
//   enable      run request (level)
//   periodo     PRI length in clk cycles
//   retardo     cycles from period start to sinc rise
//   ancho       sinc high time in cycles
//   num_pulsos  periods per burst, 0 = continuous
//   sinc        gate to the code generator
//   frame_start one-cycle strobe at period counter = 0
//   busy        generator running
//   done        burst complete
//   cfg_err     invalid config seen at start
//   pulse_cnt   periods started in the current burst
interface pulse_timing_generator_if #(
   parameter int NB_REG  = 32,
   parameter int NB_PCNT = 16
);
   logic               enable;
   logic [NB_REG-1:0]  periodo;
   logic [NB_REG-1:0]  retardo;
   logic [NB_REG-1:0]  ancho;
   logic [NB_PCNT-1:0] num_pulsos;
   logic               sinc;
   logic               frame_start;
   logic               busy;
   logic               done;
   logic               cfg_err;
   logic [NB_PCNT-1:0] pulse_cnt;

   modport master (
      output enable, periodo, retardo, ancho, num_pulsos,
      input  sinc, frame_start, busy, done, cfg_err, pulse_cnt
   );

   modport slave (
      input  enable, periodo, retardo, ancho, num_pulsos,
      output sinc, frame_start, busy, done, cfg_err, pulse_cnt
   );
endinterface

// File: rtl/pulse_timing_generator.sv
// Transmit pulse-repetition timing for the HFSWR transmitter.
// Opens one sinc gate window per PRI with programmable delay, width, period
// and burst length. Timing config is shadowed at every period start.
// Ports:
//   clk  system clock
//   rst  synchronous, active-low reset
//   bus  pulse_timing_generator_if.slave (config in, sinc/status out)
// All outputs are registered.
module pulse_timing_generator #(
   parameter int NB_REG  = 32,
   parameter int NB_PCNT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   pulse_timing_generator_if.slave   bus
);

   localparam logic [NB_REG-1:0]  ONE_R = NB_REG'(1);
   localparam logic [NB_REG-1:0]  TWO_R = NB_REG'(2);
   localparam logic [NB_PCNT-1:0] ONE_P = NB_PCNT'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [NB_REG-1:0]  pc;
   logic [NB_REG-1:0]  periodo_sh, retardo_sh, ancho_sh;
   logic [NB_PCNT-1:0] num_sh;
   logic [NB_PCNT-1:0] pulse_cnt_r;
   logic               sinc_r, frame_start_r, busy_r, done_r, cfg_err_r;

   // Window test on the value pc will hold next cycle, so the registered
   // sinc lines up with the registered pc. The end bound is one bit wider
   // than the operands so retardo+ancho never wraps.
   function automatic logic in_window(input logic [NB_REG-1:0] p,
                                      input logic [NB_REG-1:0] r,
                                      input logic [NB_REG-1:0] a);
      logic [NB_REG:0] stop;
      stop = {1'b0, r} + {1'b0, a};
      return (p >= r) && ({1'b0, p} < stop);
   endfunction

   logic period_end, burst_end;
   assign period_end = (pc == periodo_sh - ONE_R);
   assign burst_end  = (num_sh != '0) && (pulse_cnt_r == num_sh);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         pc            <= '0;
         pulse_cnt_r   <= '0;
         periodo_sh    <= '0;
         retardo_sh    <= '0;
         ancho_sh      <= '0;
         num_sh        <= '0;
         sinc_r        <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         cfg_err_r     <= 1'b0;
      end else begin
         frame_start_r <= 1'b0;
         case (state)
            IDLE: begin
               sinc_r <= 1'b0;
               busy_r <= 1'b0;
               done_r <= 1'b0;
               if (bus.enable) begin
                  if (bus.periodo >= TWO_R) begin
                     periodo_sh    <= bus.periodo;
                     retardo_sh    <= bus.retardo;
                     ancho_sh      <= bus.ancho;
                     num_sh        <= bus.num_pulsos;
                     pc            <= '0;
                     pulse_cnt_r   <= ONE_P;
                     frame_start_r <= 1'b1;
                     sinc_r        <= in_window('0, bus.retardo, bus.ancho);
                     busy_r        <= 1'b1;
                     cfg_err_r     <= 1'b0;
                     state         <= RUN;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (period_end) begin
                  if (burst_end) begin
                     sinc_r <= 1'b0;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else if (!bus.enable) begin
                     // graceful stop: only taken once the period has completed
                     sinc_r <= 1'b0;
                     busy_r <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     // no dead cycle between periods; continuous mode lets
                     // pulse_cnt wrap naturally
                     periodo_sh    <= bus.periodo;
                     retardo_sh    <= bus.retardo;
                     ancho_sh      <= bus.ancho;
                     num_sh        <= bus.num_pulsos;
                     pc            <= '0;
                     pulse_cnt_r   <= pulse_cnt_r + ONE_P;
                     frame_start_r <= 1'b1;
                     sinc_r        <= in_window('0, bus.retardo, bus.ancho);
                  end
               end else begin
                  pc     <= pc + ONE_R;
                  sinc_r <= in_window(pc + ONE_R, retardo_sh, ancho_sh);
               end
            end
            DONE: begin
               sinc_r <= 1'b0;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               // a new burst requires enable to go low first
               if (!bus.enable) begin
                  done_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sinc        = sinc_r;
   assign bus.frame_start = frame_start_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.cfg_err     = cfg_err_r;
   assign bus.pulse_cnt   = pulse_cnt_r;

endmodule

// File: tb/tb_pulse_timing_generator.sv
// Scoreboard bench for pulse_timing_generator. Stimulus pushes the hand-
// computed cycle of every frame_start / sinc edge / done rise; a negedge
// monitor pops and compares each event as the DUT produces it.
module tb_pulse_timing_generator;

   localparam int NB_REG  = 32;
   localparam int NB_PCNT = 16;
   localparam int K_FALL  = 0;
   localparam int K_FS    = 1;
   localparam int K_RISE  = 2;
   localparam int K_DONE  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   pulse_timing_generator_if #(.NB_REG(NB_REG), .NB_PCNT(NB_PCNT)) bus();

   pulse_timing_generator #(.NB_REG(NB_REG), .NB_PCNT(NB_PCNT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   ev_t  q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   logic prev_sinc = 1'b0;
   logic prev_done = 1'b0;

   function automatic string kname(input int k);
      case (k)
         K_FALL:  return "sinc_fall";
         K_FS:    return "frame_start";
         K_RISE:  return "sinc_rise";
         default: return "done_rise";
      endcase
   endfunction

   task automatic expect_ev(input int k, input int c, input int v);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic got_ev(input int k, input int v);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got event at cycle %0d, required none", kname(k), cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.val != v) begin
            errors++;
            $display("FAIL event_%s: got %s@%0d val=%0d, required %s@%0d val=%0d",
                     kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
         end
      end
   endtask

   // Same-cycle ordering: a falling sinc closes the previous period before
   // the next frame_start; a rising sinc follows its own frame_start.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_sinc && !bus.sinc)  got_ev(K_FALL, 0);
         if (bus.frame_start)         got_ev(K_FS, int'(bus.pulse_cnt));
         if (!prev_sinc && bus.sinc)  got_ev(K_RISE, 0);
         if (!prev_done && bus.done)  got_ev(K_DONE, 0);
      end
      prev_sinc <= bus.sinc;
      prev_done <= bus.done;
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", q.size(), 0);
      if (q.size() != 0) q.delete();
   endtask

   task automatic set_cfg(input int p, input int r, input int a, input int n);
      bus.periodo    = NB_REG'(p);
      bus.retardo    = NB_REG'(r);
      bus.ancho      = NB_REG'(a);
      bus.num_pulsos = NB_PCNT'(n);
   endtask

   function automatic int all_outs();
      return int'({bus.sinc, bus.frame_start, bus.busy, bus.done, bus.cfg_err, bus.pulse_cnt});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bus.enable = 1'b0;
      set_cfg(20, 3, 5, 0);
      rst = 1'b0;
      tick(3);
      check("reset_outputs", all_outs(), 0);
      rst = 1'b1;
      mon_en = 1'b1;
      tick(1);

      // basic continuous timing, graceful stop in the third period
      set_cfg(20, 3, 5, 0);
      bus.enable = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         expect_ev(K_FS,   s + 20*k,     k + 1);
         expect_ev(K_RISE, s + 20*k + 3, 0);
         expect_ev(K_FALL, s + 20*k + 8, 0);
      end
      wait_cyc(s + 45);
      check("t1_busy_running", int'(bus.busy), 1);
      bus.enable = 1'b0;
      wait_cyc(s + 59);
      check("t1_busy_last_cycle", int'(bus.busy), 1);
      tick(1);
      check("t1_busy_after_stop", int'(bus.busy), 0);
      drain(5);

      // burst of 3, done, hold enable, re-arm
      set_cfg(10, 0, 4, 3);
      bus.enable = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         expect_ev(K_FS,   s + 10*k,     k + 1);
         expect_ev(K_RISE, s + 10*k,     0);
         expect_ev(K_FALL, s + 10*k + 4, 0);
      end
      expect_ev(K_DONE, s + 30, 0);
      wait_cyc(s + 45);
      check("t2_done_held", int'(bus.done), 1);
      check("t2_busy_in_done", int'(bus.busy), 0);
      check("t2_pulse_cnt_final", int'(bus.pulse_cnt), 3);
      bus.enable = 1'b0;
      tick(1);
      check("t2_done_cleared", int'(bus.done), 0);
      bus.enable = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         expect_ev(K_FS,   s + 10*k,     k + 1);
         expect_ev(K_RISE, s + 10*k,     0);
         expect_ev(K_FALL, s + 10*k + 4, 0);
      end
      expect_ev(K_DONE, s + 30, 0);
      wait_cyc(s + 30);
      check("t2_second_done", int'(bus.done), 1);
      bus.enable = 1'b0;
      tick(1);
      check("t2_second_done_cleared", int'(bus.done), 0);
      drain(5);

      // clipped window, then ancho=0 from the next period on
      set_cfg(8, 5, 10, 0);
      bus.enable = 1'b1;
      s = cyc + 1;
      expect_ev(K_FS,   s,      1);
      expect_ev(K_RISE, s + 5,  0);
      expect_ev(K_FALL, s + 8,  0);
      expect_ev(K_FS,   s + 8,  2);
      expect_ev(K_FS,   s + 16, 3);
      expect_ev(K_FS,   s + 24, 4);
      wait_cyc(s + 2);
      bus.ancho = '0;
      wait_cyc(s + 26);
      bus.enable = 1'b0;
      wait_cyc(s + 31);
      check("t3_busy_last_cycle", int'(bus.busy), 1);
      tick(1);
      check("t3_busy_after_stop", int'(bus.busy), 0);
      drain(5);

      // shadowed ancho change and enable drop at pc=1
      set_cfg(12, 1, 4, 0);
      bus.enable = 1'b1;
      s = cyc + 1;
      expect_ev(K_FS,   s,      1);
      expect_ev(K_RISE, s + 1,  0);
      expect_ev(K_FALL, s + 5,  0);
      expect_ev(K_FS,   s + 12, 2);
      expect_ev(K_RISE, s + 13, 0);
      expect_ev(K_FALL, s + 19, 0);
      expect_ev(K_FS,   s + 24, 3);
      expect_ev(K_RISE, s + 25, 0);
      expect_ev(K_FALL, s + 31, 0);
      wait_cyc(s + 2);
      bus.ancho = NB_REG'(6);
      wait_cyc(s + 25);
      bus.enable = 1'b0;
      wait_cyc(s + 35);
      check("t4_busy_last_cycle", int'(bus.busy), 1);
      tick(1);
      check("t4_busy_after_stop", int'(bus.busy), 0);
      drain(5);

      // invalid period, recovery, reset while sinc is high
      set_cfg(1, 2, 3, 0);
      bus.enable = 1'b1;
      tick(2);
      check("t5_cfg_err_set", int'(bus.cfg_err), 1);
      check("t5_busy_on_err", int'(bus.busy), 0);
      check("t5_sinc_on_err", int'(bus.sinc), 0);
      bus.periodo = NB_REG'(16);
      s = cyc + 1;
      expect_ev(K_FS,   s,     1);
      expect_ev(K_RISE, s + 2, 0);
      expect_ev(K_FALL, s + 4, 0);
      wait_cyc(s);
      check("t5_cfg_err_cleared", int'(bus.cfg_err), 0);
      check("t5_busy_started", int'(bus.busy), 1);
      wait_cyc(s + 3);
      check("t5_sinc_before_reset", int'(bus.sinc), 1);
      rst = 1'b0;
      tick(1);
      check("t5_outputs_after_reset", all_outs(), 0);
      bus.enable = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(2);
      drain(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
